mem_port_arbiter: RTL and testbench

Shares the core's single byte-wide memory port between the instruction-fetch requester and the load/store requester. Each request is serialised into 1, 2 or 4 little-endian byte beats. Returned load data is assembled and sign- or zero-extended per RV32I `funct3`. The block sits between the multi-cycle core's FETCH/MEMACC stages and the `mem` byte array.

---
 rtl/mem_port_arbiter_pkg.sv | 69 ++++++
 rtl/mem_port_arbiter_if.sv | 46 ++++
 rtl/mem_port_arbiter_load_extend.sv | 28 ++
 rtl/mem_port_arbiter.sv | 169 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and constants for the byte-wide memory port
//               arbiter: FSM states, RV32I load/store funct3 codes, beat
//               counts and the funct3 size/sign decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } arb_state_t;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    // Number of byte beats in a transfer
    localparam logic [2:0] NB_1 = 3'd1;
    localparam logic [2:0] NB_2 = 3'd2;
    localparam logic [2:0] NB_4 = 3'd4;

    typedef struct packed {
        logic [2:0] nbytes;
        logic       sgn;
        logic       legal;
    } size_dec_t;

    // Fetches are always an unextended word; data accesses decode funct3.
    function automatic size_dec_t size_decode(input logic       is_data,
                                              input logic       we,
                                              input logic [2:0] funct3);
        size_dec_t d;
        d.nbytes = NB_4;
        d.sgn    = 1'b0;
        d.legal  = 1'b1;
        if (is_data) begin
            if (we) begin
                case (funct3)
                    SB:      d.nbytes = NB_1;
                    SH:      d.nbytes = NB_2;
                    SW:      d.nbytes = NB_4;
                    default: d.legal  = 1'b0;
                endcase
            end else begin
                case (funct3)
                    LB:      begin d.nbytes = NB_1; d.sgn = 1'b1; end
                    LH:      begin d.nbytes = NB_2; d.sgn = 1'b1; end
                    LW:      d.nbytes = NB_4;
                    LBU:     d.nbytes = NB_1;
                    LHU:     d.nbytes = NB_2;
                    default: d.legal  = 1'b0;
                endcase
            end
        end
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_if
// Description : Bundle of the fetch requester, data requester and byte memory
//               port signals around the arbiter.
//               slave  : arbiter side (takes requests, drives memory port)
//               master : environment side (requesters and memory)
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 10
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic [31:0]       if_rdata;

    logic              d_req;
    logic              d_we;
    logic [2:0]        d_funct3;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic              d_ack;
    logic [31:0]       d_rdata;
    logic              d_err;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;

    logic              busy;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_funct3, d_addr, d_wdata, mem_rdata,
        output if_ack, if_rdata, d_ack, d_rdata, d_err,
               mem_addr, mem_we, mem_wdata, busy
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_funct3, d_addr, d_wdata, mem_rdata,
        input  if_ack, if_rdata, d_ack, d_rdata, d_err,
               mem_addr, mem_we, mem_wdata, busy
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter_load_extend.sv
`default_nettype none
// ============================================================================
// Module      : load_extend
// Description : Combinational sign/zero extension of an assembled load word.
// Ports       : i_raw    - bytes assembled little-endian from lane 0 up
//               i_nbytes - 1, 2 or 4 valid bytes
//               i_sgn    - replicate the top valid bit when set
//               o_ext    - extended 32-bit result
// Revision    : 1.0 - initial release
// ============================================================================
module load_extend
    import mem_arb_pkg::*;
(
    input  wire logic [31:0] i_raw,
    input  wire logic [2:0]  i_nbytes,
    input  wire logic        i_sgn,
    output logic      [31:0] o_ext
);
    always_comb begin
        o_ext = i_raw;
        case (i_nbytes)
            NB_1:    o_ext = {{24{i_sgn & i_raw[7]}},  i_raw[7:0]};
            NB_2:    o_ext = {{16{i_sgn & i_raw[15]}}, i_raw[15:0]};
            default: o_ext = i_raw;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Round-robin share of one byte-wide synchronous memory port
//               between instruction fetch and load/store. Each request is
//               split into 1/2/4 little-endian byte beats; loads are
//               reassembled and extended per RV32I funct3.
// Ports       : clk, rst - clock and synchronous active-high reset
//               bus      - requesters, memory port and busy (slave modport)
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  wire logic        clk,
    input  wire logic        rst,
    mem_port_arbiter_if.slave bus
);
    arb_state_t        r_state, w_state_nxt;

    logic              r_gnt_d;     // 1: data requester owns the transfer
    logic              r_last_d;    // round-robin pointer, 1: data granted last
    logic              r_we;
    logic              r_sgn;
    logic [2:0]        r_nbytes;
    logic [1:0]        r_beat;
    logic [ADDR_W-1:0] r_base;
    logic [31:0]       r_wdata;
    logic [31:0]       r_raw;
    logic              r_busy;
    logic              r_if_ack, r_d_ack, r_d_err;
    logic [31:0]       r_if_rdata, r_d_rdata;

    logic              w_req_any;
    logic              w_grant_d;
    size_dec_t         w_dec;
    logic              w_last_beat;
    logic [31:0]       w_raw_merged;
    logic [31:0]       w_ext;
    logic [ADDR_W-1:0] w_mem_addr;
    logic              w_mem_we;
    logic [7:0]        w_mem_wdata;

    // Under contention the requester not served last wins.
    always_comb begin
        w_req_any = bus.if_req | bus.d_req;
        w_grant_d = bus.d_req & (~bus.if_req | ~r_last_d);
        w_dec     = size_decode(w_grant_d, bus.d_we, bus.d_funct3);
    end

    assign w_last_beat = ({1'b0, r_beat} == (r_nbytes - 3'd1));

    // The byte arriving now was addressed one beat earlier, so it lands in
    // lane beat-1. In WAIT the beat counter has already stepped past the
    // last beat (modulo 4), so the same lane formula covers the final byte.
    always_comb begin
        w_raw_merged = r_raw;
        w_raw_merged[{r_beat - 2'd1, 3'b000} +: 8] = bus.mem_rdata;
    end

    load_extend u_load_extend (
        .i_raw    (w_raw_merged),
        .i_nbytes (r_nbytes),
        .i_sgn    (r_sgn),
        .o_ext    (w_ext)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_req_any) w_state_nxt = w_dec.legal ? ST_XFER : ST_RESP;
            ST_XFER: if (w_last_beat) w_state_nxt = ST_WAIT;
            ST_WAIT: w_state_nxt = ST_RESP;
            ST_RESP: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_gnt_d    <= 1'b0;
            r_last_d   <= 1'b0;
            r_we       <= 1'b0;
            r_sgn      <= 1'b0;
            r_nbytes   <= NB_4;
            r_beat     <= 2'd0;
            r_base     <= '0;
            r_wdata    <= '0;
            r_raw      <= '0;
            r_busy     <= 1'b0;
            r_if_ack   <= 1'b0;
            r_d_ack    <= 1'b0;
            r_d_err    <= 1'b0;
            r_if_rdata <= '0;
            r_d_rdata  <= '0;
        end else begin
            r_if_ack <= 1'b0;
            r_d_ack  <= 1'b0;
            r_d_err  <= 1'b0;
            r_busy   <= (w_state_nxt != ST_IDLE);
            case (r_state)
                ST_IDLE: begin
                    if (w_req_any) begin
                        r_gnt_d  <= w_grant_d;
                        r_base   <= w_grant_d ? bus.d_addr : bus.if_addr;
                        r_we     <= w_grant_d & bus.d_we;
                        r_nbytes <= w_dec.nbytes;
                        r_sgn    <= w_dec.sgn;
                        r_wdata  <= bus.d_wdata;
                        r_beat   <= 2'd0;
                        r_raw    <= '0;
                        // Illegal funct3 skips the memory and answers next cycle.
                        if (!w_dec.legal) begin
                            r_d_ack   <= 1'b1;
                            r_d_err   <= 1'b1;
                            r_d_rdata <= '0;
                        end
                    end
                end
                ST_XFER: begin
                    r_beat <= r_beat + 2'd1;
                    if (r_beat != 2'd0 && !r_we) r_raw <= w_raw_merged;
                end
                ST_WAIT: begin
                    if (r_gnt_d) begin
                        r_d_ack   <= 1'b1;
                        r_d_rdata <= r_we ? 32'd0 : w_ext;
                    end else begin
                        r_if_ack   <= 1'b1;
                        r_if_rdata <= w_ext;
                    end
                end
                ST_RESP: r_last_d <= r_gnt_d;
                default: ;
            endcase
        end
    end

    // Memory port decodes straight from state and beat; address wraps.
    always_comb begin
        w_mem_addr  = '0;
        w_mem_we    = 1'b0;
        w_mem_wdata = 8'd0;
        if (r_state == ST_XFER) begin
            w_mem_addr = r_base + ADDR_W'(r_beat);
            w_mem_we   = r_we;
            if (r_we) w_mem_wdata = r_wdata[{r_beat, 3'b000} +: 8];
        end
    end

    assign bus.mem_addr  = w_mem_addr;
    assign bus.mem_we    = w_mem_we;
    assign bus.mem_wdata = w_mem_wdata;
    assign bus.if_ack    = r_if_ack;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.d_ack     = r_d_ack;
    assign bus.d_rdata   = r_d_rdata;
    assign bus.d_err     = r_d_err;
    assign bus.busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Scoreboard bench for mem_port_arbiter with a byte memory
//               model. Requests push expected responses; a monitor pops and
//               compares on every ack.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    int         cyc = 0;
    int         n_checks = 0;
    int         n_errors = 0;
    int         we_cnt = 0;
    int         we0;

    logic [7:0] mem [0:1023];
    logic       pl_we = 1'b0;
    logic [9:0] pl_addr = '0;
    logic [7:0] pl_data = '0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;
    exp_t q_d[$];
    exp_t q_if[$];

    mem_port_arbiter_if #(.ADDR_W(10)) bus();

    mem_port_arbiter #(.ADDR_W(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read byte memory with a preload port for the bench.
    always @(posedge clk) begin
        if (pl_we)           mem[pl_addr] <= pl_data;
        else if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= mem[bus.mem_addr];
    end

    always @(negedge clk) if (bus.mem_we) we_cnt <= we_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor
    exp_t em;
    always @(negedge clk) begin
        if (!rst && bus.d_ack) begin
            if (q_d.size() == 0) check("unexpected d_ack", 32'(bus.d_ack), 32'd0);
            else begin
                em = q_d.pop_front();
                check("d_rdata", bus.d_rdata, em.rdata);
                check("d_err", 32'(bus.d_err), 32'(em.err));
                check("d_ack cycle", 32'(cyc), 32'(em.cyc));
            end
        end
        if (!rst && bus.if_ack) begin
            if (q_if.size() == 0) check("unexpected if_ack", 32'(bus.if_ack), 32'd0);
            else begin
                em = q_if.pop_front();
                check("if_rdata", bus.if_rdata, em.rdata);
                check("if_ack cycle", 32'(cyc), 32'(em.cyc));
            end
        end
    end

    task automatic poke(input logic [9:0] a, input logic [7:0] d);
        pl_addr = a; pl_data = d; pl_we = 1'b1;
        @(posedge clk); #1;
        pl_we = 1'b0;
    endtask

    task automatic data_op(input logic we, input logic [2:0] f3, input logic [9:0] addr,
                           input logic [31:0] wd, input logic [31:0] exp_rd,
                           input logic exp_err, input int ack_off);
        exp_t e;
        bit   seen = 1'b0;
        bus.d_we = we; bus.d_funct3 = f3; bus.d_addr = addr; bus.d_wdata = wd;
        bus.d_req = 1'b1;
        e.rdata = exp_rd; e.err = exp_err; e.cyc = cyc + ack_off;
        q_d.push_back(e);
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = bus.d_ack;
        end
        if (!seen) check("d_ack timeout", 32'(seen), 32'd1);
        bus.d_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic fetch_op(input logic [9:0] addr, input logic [31:0] exp_rd, input int ack_off);
        exp_t e;
        bit   seen = 1'b0;
        bus.if_addr = addr;
        bus.if_req  = 1'b1;
        e.rdata = exp_rd; e.err = 1'b0; e.cyc = cyc + ack_off;
        q_if.push_back(e);
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = bus.if_ack;
        end
        if (!seen) check("if_ack timeout", 32'(seen), 32'd1);
        bus.if_req = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_funct3 = 3'd0;
        bus.d_addr = '0; bus.d_wdata = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        poke(10'd0, 8'hB7);   poke(10'd1, 8'hA0);
        poke(10'd2, 8'hAA);   poke(10'd3, 8'hAA);
        poke(10'd100, 8'h80); poke(10'd101, 8'hF0);
        poke(10'd102, 8'h00); poke(10'd103, 8'h00); poke(10'd104, 8'hC3);
        poke(10'd200, 8'h5A); poke(10'd201, 8'h5B);
        poke(10'd202, 8'h5C); poke(10'd203, 8'h5D);
        poke(10'd1022, 8'h11); poke(10'd1023, 8'h22);
        rst = 1'b0;

        @(negedge clk);
        check("reset busy",      32'(bus.busy),      32'd0);
        check("reset if_ack",    32'(bus.if_ack),    32'd0);
        check("reset d_ack",     32'(bus.d_ack),     32'd0);
        check("reset d_err",     32'(bus.d_err),     32'd0);
        check("reset mem_we",    32'(bus.mem_we),    32'd0);
        check("reset mem_addr",  32'(bus.mem_addr),  32'd0);
        check("reset mem_wdata", 32'(bus.mem_wdata), 32'd0);
        check("reset if_rdata",  bus.if_rdata,       32'd0);
        check("reset d_rdata",   bus.d_rdata,        32'd0);
        @(posedge clk); #1;

        // Loads: word, signed/unsigned byte and half
        data_op(1'b0, LW,  10'd0,   32'd0, 32'hAAAAA0B7, 1'b0, 6);
        data_op(1'b0, LB,  10'd100, 32'd0, 32'hFFFFFF80, 1'b0, 3);
        data_op(1'b0, LBU, 10'd100, 32'd0, 32'h00000080, 1'b0, 3);
        data_op(1'b0, LH,  10'd100, 32'd0, 32'hFFFFF080, 1'b0, 4);
        data_op(1'b0, LHU, 10'd100, 32'd0, 32'h0000F080, 1'b0, 4);

        // Halfword store
        we0 = we_cnt;
        data_op(1'b1, SH, 10'd102, 32'h12345678, 32'd0, 1'b0, 4);
        check("SH mem[102]", 32'(mem[102]), 32'h78);
        check("SH mem[103]", 32'(mem[103]), 32'h56);
        check("SH mem[104]", 32'(mem[104]), 32'hC3);
        check("SH mem_we cycles", 32'(we_cnt - we0), 32'd2);

        // Illegal funct3 for load and store: immediate error, no memory access
        we0 = we_cnt;
        data_op(1'b0, 3'b011, 10'd0, 32'd0, 32'd0, 1'b1, 1);
        data_op(1'b1, 3'b100, 10'd5, 32'hFFFFFFFF, 32'd0, 1'b1, 1);
        check("illegal mem_we cycles", 32'(we_cnt - we0), 32'd0);

        // Address wrap: lanes from 1022, 1023, 0, 1
        data_op(1'b0, LW, 10'd1022, 32'd0, 32'hA0B72211, 1'b0, 6);

        // Fresh reset so the round-robin pointer starts at "fetch last"
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Contention after reset: data first, fetch after
        fork
            data_op(1'b0, LB, 10'd100, 32'd0, 32'hFFFFFF80, 1'b0, 3);
            fetch_op(10'd0, 32'hAAAAA0B7, 10);
        join
        // Data alone, then contention again: fetch wins this time
        data_op(1'b0, LBU, 10'd100, 32'd0, 32'h00000080, 1'b0, 3);
        fork
            fetch_op(10'd1022, 32'hA0B72211, 6);
            data_op(1'b0, LB, 10'd100, 32'd0, 32'hFFFFFF80, 1'b0, 10);
        join

        // Reset during a word store: reset sampled at the edge that would start beat 2
        bus.d_we = 1'b1; bus.d_funct3 = SW; bus.d_addr = 10'd200;
        bus.d_wdata = 32'hDDCCBBAA; bus.d_req = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1; bus.d_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("busy after mid reset", 32'(bus.busy), 32'd0);
        for (int i = 0; i < 8; i++) begin
            check("no d_ack after mid reset", 32'(bus.d_ack), 32'd0);
            @(negedge clk);
        end
        check("mid reset mem[200]", 32'(mem[200]), 32'hAA);
        check("mid reset mem[201]", 32'(mem[201]), 32'hBB);
        check("mid reset mem[202]", 32'(mem[202]), 32'h5C);
        check("mid reset mem[203]", 32'(mem[203]), 32'h5D);

        check("d queue drained",  32'(q_d.size()),  32'd0);
        check("if queue drained", 32'(q_if.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
